gauss3x3_sink: RTL and testbench

Receiving end of the 3x3 window serializer. Accepts one window per burst as three consecutive column beats, each carrying top, middle and bottom row bytes. Reassembles the 3x3 window and applies the fixed Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16, emitting one filtered pixel per window. Sits between the window serializer and the scale-space / difference stage of the stitching pipeline.

---
 rtl/gauss3x3_sink_if.sv | 22 ++
 rtl/gauss3x3_sink.sv | 78 +++++++
 tb/tb_gauss3x3_sink.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gauss3x3_sink_if.sv
// gauss3x3_sink_if: column-beat input and filtered-pixel output bundle of the 3x3 Gaussian sink.
interface gauss3x3_sink_if #(parameter int DATA_W = 8, parameter int CNT_W = 16);
  logic              valid_i;
  logic              idle_i;
  logic              done_i;
  logic [DATA_W-1:0] row0_i;
  logic [DATA_W-1:0] row1_i;
  logic [DATA_W-1:0] row2_i;
  logic [DATA_W-1:0] pix_o;
  logic              pix_valid_o;
  logic              line_done_o;
  logic [CNT_W-1:0]  win_count_o;
  logic              err_o;
  modport master (
    output valid_i, idle_i, done_i, row0_i, row1_i, row2_i,
    input  pix_o, pix_valid_o, line_done_o, win_count_o, err_o
  );
  modport slave (
    input  valid_i, idle_i, done_i, row0_i, row1_i, row2_i,
    output pix_o, pix_valid_o, line_done_o, win_count_o, err_o
  );
endinterface

// File: rtl/gauss3x3_sink.sv
// gauss3x3_sink: reassembles 3-beat column bursts into a 3x3 window and applies the [1 2 1]x[1 2 1]/16 kernel.
// GAUSS_ROUND_EN selects round-half-up instead of truncation on the final >>4.
module gauss3x3_sink #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst_n,
  gauss3x3_sink_if.slave bus
);
  localparam int VW = DATA_W + 2;
  localparam int SW = DATA_W + 4;
  localparam logic [1:0] IDLE = 2'd0, COL1 = 2'd1, COL2 = 2'd2;
`ifdef GAUSS_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(8);
`else
  localparam logic [SW-1:0] RND = '0;
`endif
  logic [1:0]               state, state_n;
  logic [2:0][3*DATA_W-1:0] win;
  logic [2:0][VW-1:0]       vs;
  logic [SW-1:0]            sum;
  logic [DATA_W-1:0]        pix, pix_n;
  logic [CNT_W-1:0]         cnt;
  logic done_q, done_rise, viol, take, go, s1_v, pix_v, dr1, dr2, ld, err;

  // each window column is packed {bottom, middle, top}
  function automatic logic [VW-1:0] vsum(input logic [3*DATA_W-1:0] c);
    return VW'(c[DATA_W-1:0]) + (VW'(c[2*DATA_W-1:DATA_W]) << 1) + VW'(c[3*DATA_W-1:2*DATA_W]);
  endfunction

  always_comb begin
    done_rise = bus.done_i & ~done_q;
    viol      = (state != IDLE) & (~bus.valid_i | done_rise | bus.idle_i);
    take      = bus.valid_i & ~viol;
    state_n   = viol ? IDLE : !take ? state : state == COL2 ? IDLE : state + 2'd1;
    sum       = SW'(vs[0]) + (SW'(vs[1]) << 1) + SW'(vs[2]);
    pix_n     = DATA_W'((sum + RND) >> 4);
  end

  // line_done rides a 3-register delay matching capture -> column sums -> pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
      err    <= 1'b0;
      win    <= '0;
      go     <= 1'b0;
      s1_v   <= 1'b0;
      vs     <= '0;
      pix_v  <= 1'b0;
      pix    <= '0;
      cnt    <= '0;
      dr1    <= 1'b0;
      dr2    <= 1'b0;
      ld     <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= bus.done_i;
      err    <= err | viol;
      if (take) win[state] <= {bus.row2_i, bus.row1_i, bus.row0_i};
      go     <= take & (state == COL2);
      s1_v   <= go;
      if (go) vs <= {vsum(win[2]), vsum(win[1]), vsum(win[0])};
      pix_v  <= s1_v;
      if (s1_v) pix <= pix_n;
      cnt    <= cnt + CNT_W'(s1_v);
      dr1    <= done_rise;
      dr2    <= dr1;
      ld     <= dr2;
    end

  assign bus.pix_o       = pix;
  assign bus.pix_valid_o = pix_v;
  assign bus.line_done_o = ld;
  assign bus.win_count_o = cnt;
  assign bus.err_o       = err;
endmodule

// File: tb/tb_gauss3x3_sink.sv
// tb_gauss3x3_sink: random and directed column bursts checked against a window-level reference model.
module tb_gauss3x3_sink;
`ifdef GAUSS_ROUND_EN
  localparam int RND = 8, CENTRE = 64, CORNER = 16;
`else
  localparam int RND = 0, CENTRE = 63, CORNER = 15;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0, n_err = 0, cyc = 0;
  gauss3x3_sink_if #(.DATA_W(8), .CNT_W(16)) bus ();
  gauss3x3_sink #(.DATA_W(8), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [23:0] cols[$];
  int  px_at[int];
  bit  ld_at[int];
  bit  m_err, dn_prev;
  int  m_cnt, m_pix;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int gauss(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2);
    logic [23:0] w[3];
    int s;
    w[0] = c0; w[1] = c1; w[2] = c2;
    s = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        s += ((c == 1) ? 2 : 1) * ((r == 1) ? 2 : 1) * int'(w[c][8*r +: 8]);
    return (s + RND) >> 4;
  endfunction

  task automatic model_clear();
    cols.delete(); px_at.delete(); ld_at.delete();
    m_err = 0; m_cnt = 0; m_pix = 0; dn_prev = 0;
  endtask

  task automatic tick(input bit v, input bit idl, input bit dn, input logic [23:0] col);
    bit rise, pv_e, ld_e;
    bus.valid_i = v; bus.idle_i = idl; bus.done_i = dn;
    bus.row0_i = col[7:0]; bus.row1_i = col[15:8]; bus.row2_i = col[23:16];
    @(posedge clk);
    cyc++;
    rise = dn && !dn_prev;
    dn_prev = dn;
    if (rise) ld_at[cyc + 2] = 1;
    if (cols.size() != 0) begin
      if (!v || rise || idl) begin
        m_err = 1;
        cols.delete();
      end else begin
        cols.push_back(col);
        if (cols.size() == 3) begin
          px_at[cyc + 2] = gauss(cols[0], cols[1], cols[2]);
          cols.delete();
        end
      end
    end else if (v) cols.push_back(col);
    @(negedge clk);
    pv_e = px_at.exists(cyc);
    if (pv_e) begin
      m_pix = px_at[cyc];
      m_cnt = (m_cnt + 1) & 16'hffff;
      px_at.delete(cyc);
    end
    ld_e = ld_at.exists(cyc);
    if (ld_e) ld_at.delete(cyc);
    chk("pix_valid", int'(bus.pix_valid_o), int'(pv_e));
    chk("line_done", int'(bus.line_done_o), int'(ld_e));
    chk("pix", int'(bus.pix_o), m_pix);
    chk("win_count", int'(bus.win_count_o), m_cnt);
    chk("err", int'(bus.err_o), int'(m_err));
  endtask

  task automatic burst(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2);
    tick(1, 0, 0, c0);
    tick(1, 0, 0, c1);
    tick(1, 0, 0, c2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid_i = 0; bus.idle_i = 1; bus.done_i = 0;
    bus.row0_i = 0; bus.row1_i = 0; bus.row2_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_pix", int'(bus.pix_o), 0);
    chk("rst_pix_valid", int'(bus.pix_valid_o), 0);
    chk("rst_line_done", int'(bus.line_done_o), 0);
    chk("rst_win_count", int'(bus.win_count_o), 0);
    chk("rst_err", int'(bus.err_o), 0);
    model_clear();
    rst_n = 1'b1;
  endtask

  initial begin
    bit v, idl, dn_lvl;
    int md, gap;
    do_reset();
    // flat field, centre and corner impulses, full scale
    burst({3{8'd100}}, {3{8'd100}}, {3{8'd100}});
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    chk("flat_pix", int'(bus.pix_o), 100);
    chk("flat_valid", int'(bus.pix_valid_o), 1);
    chk("flat_count", int'(bus.win_count_o), 1);
    chk("flat_err", int'(bus.err_o), 0);
    burst(24'h0, 24'h00ff00, 24'h0);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    chk("centre_pix", int'(bus.pix_o), CENTRE);
    burst(24'h0000ff, 24'h0, 24'h0);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    chk("corner_pix", int'(bus.pix_o), CORNER);
    burst(24'hffffff, 24'hffffff, 24'hffffff);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    chk("full_pix", int'(bus.pix_o), 255);
    chk("full_count", int'(bus.win_count_o), 4);
    // back-to-back bursts
    do_reset();
    burst({3{8'd10}}, {3{8'd10}}, {3{8'd10}});
    tick(1, 0, 0, {3{8'd200}});
    tick(1, 0, 0, {3{8'd200}});
    chk("b2b_first_valid", int'(bus.pix_valid_o), 1);
    chk("b2b_first_pix", int'(bus.pix_o), 10);
    tick(1, 0, 0, {3{8'd200}});
    tick(0, 1, 0, 0);
    chk("b2b_gap_valid", int'(bus.pix_valid_o), 0);
    tick(0, 1, 0, 0);
    chk("b2b_second_valid", int'(bus.pix_valid_o), 1);
    chk("b2b_second_pix", int'(bus.pix_o), 200);
    chk("b2b_count", int'(bus.win_count_o), 2);
    // truncated burst, then recovery
    do_reset();
    tick(1, 0, 0, 24'h123456);
    tick(1, 0, 0, 24'h654321);
    tick(0, 1, 0, 0);
    chk("trunc_err", int'(bus.err_o), 1);
    repeat (3) tick(0, 1, 0, 0);
    chk("trunc_count", int'(bus.win_count_o), 0);
    burst({3{8'd50}}, {3{8'd50}}, {3{8'd50}});
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    chk("recover_pix", int'(bus.pix_o), 50);
    chk("recover_err", int'(bus.err_o), 1);
    // section end: done rises the cycle after the last beat
    do_reset();
    burst({3{8'd80}}, {3{8'd80}}, {3{8'd80}});
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    chk("sect_pix_valid", int'(bus.pix_valid_o), 1);
    chk("sect_ld_early", int'(bus.line_done_o), 0);
    tick(0, 1, 1, 0);
    chk("sect_line_done", int'(bus.line_done_o), 1);
    tick(0, 1, 1, 0);
    // same section end, reset while the pipeline is loaded
    do_reset();
    burst({3{8'd80}}, {3{8'd80}}, {3{8'd80}});
    tick(0, 1, 1, 0);
    do_reset();
    repeat (4) tick(0, 1, 0, 0);
    // randomized bursts with occasional protocol faults
    dn_lvl = 0;
    for (int i = 0; i < 250; i++) begin
      md  = int'($urandom_range(0, 9));
      gap = int'($urandom_range(0, 2));
      repeat (gap) tick(0, 1, dn_lvl, 24'($urandom));
      for (int c = 0; c < 3; c++) begin
        v = 1; idl = 0;
        if (c == 0) dn_lvl = 0;
        if (md == 0 && c == int'($urandom_range(1, 2))) v = 0;
        if (md == 1 && c == 1) idl = 1;
        if (md == 2 && c == 2) dn_lvl = 1;
        tick(v, idl, dn_lvl, 24'($urandom));
      end
      if (md == 3 || md == 4) dn_lvl = 1;
    end
    repeat (3) tick(0, 1, dn_lvl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
